// File: rtl/sram_march_bist.sv
// sram_march_bist: built-in self-test engine for an external asynchronous SRAM.
// Runs address-pattern, checkerboard or March C- over 0..TOP_ADDR. Every access is
// a fixed four-cycle slot: k0 setup, k1 strobe low, k2 strobes high and compare, k3 advance.
// Stops on the first read mismatch and holds the failing address and data words.
module sram_march_bist #(
  parameter int                ADDR_W   = 19,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(19'h7FFFF)
) (
  input  logic              CLK0_OUT,
  input  logic              r_rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic [7:0]        progress,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dout,
  input  logic [DATA_W-1:0] ram_din,
  output logic              ram_drive,
  output logic              ram_we_b,
  output logic              ram_oe_b
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAIL} state_t;
  typedef enum logic [2:0] {P_A, P_CB, P_NCB, P_ZERO, P_ONE} pat_t;
  typedef struct packed {
    logic wr;
    pat_t pat;
  } op_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state;
  logic [1:0]        mode_q;
  logic [1:0]        elem;
  logic              op_q;
  logic [1:0]        phase;
  logic [DATA_W-1:0] rd_p1;

  // Operation table: which access and pattern each (mode, element, op slot) performs.
  function automatic op_t op_info(input logic [1:0] m, input logic [1:0] e, input logic o);
    op_t r;
    r.wr  = 1'b1;
    r.pat = P_ZERO;
    case (m)
      2'd1: begin
        r.wr  = ~e[0];
        r.pat = e[1] ? P_NCB : P_CB;
      end
      2'd2: begin
        case (e)
          2'd0: begin r.wr = 1'b1; r.pat = P_ZERO; end
          2'd1: begin r.wr = o;    r.pat = o ? P_ONE : P_ZERO; end
          2'd2: begin r.wr = o;    r.pat = o ? P_ZERO : P_ONE; end
          default: begin r.wr = 1'b0; r.pat = P_ZERO; end
        endcase
      end
      default: begin
        case (e)
          2'd0:    begin r.wr = 1'b1; r.pat = P_A;    end
          2'd1:    begin r.wr = 1'b0; r.pat = P_A;    end
          default: begin r.wr = 1'b1; r.pat = P_ZERO; end
        endcase
      end
    endcase
    return r;
  endfunction

  function automatic logic elem_last(input logic [1:0] m, input logic [1:0] e);
    return (m == 2'd0) ? (e == 2'd2) : (e == 2'd3);
  endfunction

  function automatic logic elem_down(input logic [1:0] m, input logic [1:0] e);
    return (m == 2'd2) && e[1];
  endfunction

  function automatic logic elem_two(input logic [1:0] m, input logic [1:0] e);
    return (m == 2'd2) && (e == 2'd1 || e == 2'd2);
  endfunction

  // Data word for a pattern at an address; address bits above 15 do not appear in A.
  function automatic logic [DATA_W-1:0] pat_data(input pat_t p, input logic [ADDR_W-1:0] a);
    logic [ADDR_W+15:0] ax;
    logic [15:0]        a16;
    logic [DATA_W-1:0]  d;
    ax  = {16'h0000, a};
    a16 = ax[15:0];
    case (p)
      P_A:     d = {(DATA_W/16){a16}};
      P_CB:    d = a[0] ? {(DATA_W/8){8'hAA}} : {(DATA_W/8){8'h55}};
      P_NCB:   d = a[0] ? {(DATA_W/8){8'h55}} : {(DATA_W/8){8'hAA}};
      P_ONE:   d = '1;
      default: d = '0;
    endcase
    return d;
  endfunction

  logic [1:0]        start_mode;
  op_t               start_op;
  op_t               cur_op;
  logic              cur_down;
  logic [ADDR_W-1:0] end_addr;
  logic [1:0]        nx_elem;
  logic              nx_opi;
  logic [ADDR_W-1:0] nx_addr;
  logic              nx_last;
  op_t               nx_op;
  logic [7:0]        prog_addr;

  assign start_mode = (mode == 2'd3) ? 2'd0 : mode;
  assign start_op   = op_info(start_mode, 2'd0, 1'b0);
  assign cur_op     = op_info(mode_q, elem, op_q);
  assign cur_down   = elem_down(mode_q, elem);
  assign end_addr   = cur_down ? '0 : TOP_ADDR;

  // Next access after k3: second op at same address, next address, or next element.
  always_comb begin
    nx_elem = elem;
    nx_opi  = 1'b0;
    nx_addr = ram_addr;
    nx_last = 1'b0;
    if (!op_q && elem_two(mode_q, elem)) begin
      nx_opi = 1'b1;
    end else if (ram_addr == end_addr) begin
      if (elem_last(mode_q, elem)) begin
        nx_last = 1'b1;
      end else begin
        nx_elem = elem + 2'd1;
        nx_addr = elem_down(mode_q, elem + 2'd1) ? TOP_ADDR : '0;
      end
    end else begin
      nx_addr = cur_down ? (ram_addr - ADDR_ONE) : (ram_addr + ADDR_ONE);
    end
    nx_op = op_info(mode_q, nx_elem, nx_opi);
  end

  // LED view uses the top eight address bits, left-aligned when the bus is narrower.
  generate
    if (ADDR_W >= 8) begin : g_prog_wide
      assign prog_addr = ram_addr[ADDR_W-1:ADDR_W-8];
    end else begin : g_prog_narrow
      assign prog_addr = {ram_addr, {(8-ADDR_W){1'b0}}};
    end
  endgenerate

  // Progress LEDs decoded from the controller state.
  always_comb begin
    case (state)
      S_RUN:   progress = prog_addr;
      S_DONE:  progress = 8'h55;
      S_FAIL:  progress = 8'h33;
      default: progress = 8'h00;
    endcase
  end

  // Read-data capture on the edge that ends the k1 strobe.
  always_ff @(posedge CLK0_OUT) begin
    if (state == S_RUN && phase == 2'd1) rd_p1 <= ram_din;
  end

  // Controller: run handshake, access slot sequencing, strobes and failure capture.
  always_ff @(posedge CLK0_OUT) begin
    if (r_rst) begin
      state     <= S_IDLE;
      mode_q    <= 2'd0;
      elem      <= 2'd0;
      op_q      <= 1'b0;
      phase     <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
      ram_addr  <= '0;
      ram_dout  <= '0;
      ram_drive <= 1'b0;
      ram_we_b  <= 1'b1;
      ram_oe_b  <= 1'b1;
    end else begin
      case (state)
        S_RUN: begin
          case (phase)
            2'd0: begin
              phase <= 2'd1;
              if (cur_op.wr) ram_we_b <= 1'b0;
              else           ram_oe_b <= 1'b0;
            end
            2'd1: begin
              phase    <= 2'd2;
              ram_we_b <= 1'b1;
              ram_oe_b <= 1'b1;
            end
            2'd2: begin
              if (!cur_op.wr && rd_p1 != ram_dout) begin
                state     <= S_FAIL;
                busy      <= 1'b0;
                fail      <= 1'b1;
                fail_addr <= ram_addr;
                fail_exp  <= ram_dout;
                fail_got  <= rd_p1;
                ram_drive <= 1'b0;
                phase     <= 2'd0;
              end else begin
                phase <= 2'd3;
              end
            end
            default: begin
              phase <= 2'd0;
              if (nx_last) begin
                state     <= S_DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
                pass      <= 1'b1;
                ram_drive <= 1'b0;
              end else begin
                elem      <= nx_elem;
                op_q      <= nx_opi;
                ram_addr  <= nx_addr;
                ram_dout  <= pat_data(nx_op.pat, nx_addr);
                ram_drive <= nx_op.wr;
              end
            end
          endcase
        end
        default: begin
          if (start) begin
            state     <= S_RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
            mode_q    <= start_mode;
            elem      <= 2'd0;
            op_q      <= 1'b0;
            phase     <= 2'd0;
            ram_addr  <= '0;
            ram_dout  <= pat_data(start_op.pat, '0);
            ram_drive <= start_op.wr;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_march_bist.sv
// tb_sram_march_bist: directed table-driven bench for sram_march_bist with a
// 16-word x 16-bit SRAM model, an optional stuck-at-1 bit and a strobe monitor.
module tb_sram_march_bist;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int N      = 16;

  logic              CLK0_OUT = 1'b0;
  logic              r_rst;
  logic              start;
  logic [1:0]        mode;
  logic              busy, done, pass, fail;
  logic [ADDR_W-1:0] fail_addr, ram_addr;
  logic [DATA_W-1:0] fail_exp, fail_got, ram_dout, ram_din;
  logic [7:0]        progress;
  logic              ram_drive, ram_we_b, ram_oe_b;
  logic              stuck_en;
  logic [15:0]       mem [N];

  int checks   = 0;
  int failures = 0;

  sram_march_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TOP_ADDR(4'd15)) dut (
    .CLK0_OUT (CLK0_OUT),
    .r_rst    (r_rst),
    .start    (start),
    .mode     (mode),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .fail_addr(fail_addr),
    .fail_exp (fail_exp),
    .fail_got (fail_got),
    .progress (progress),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .ram_din  (ram_din),
    .ram_drive(ram_drive),
    .ram_we_b (ram_we_b),
    .ram_oe_b (ram_oe_b)
  );

  always #5 CLK0_OUT = ~CLK0_OUT;

  // SRAM model: write on an edge where WE is low; read is asynchronous.
  always @(posedge CLK0_OUT) begin
    if (!ram_we_b) mem[ram_addr] <= ram_dout;
  end
  assign ram_din = mem[ram_addr] | ((stuck_en && ram_addr == 4'd9) ? 16'h0008 : 16'h0000);

  // Strobe monitor: protocol violations and a log of every access.
  int                viol = 0;
  logic              prev_we = 1'b1;
  logic              prev_oe = 1'b1;
  logic [ADDR_W-1:0] log_addr [$];
  logic              log_wr   [$];
  logic [DATA_W-1:0] log_dat  [$];
  always @(negedge CLK0_OUT) begin
    int v;
    v = 0;
    if (!ram_we_b && !ram_oe_b) v = v + 1;
    if (ram_drive && !ram_oe_b) v = v + 1;
    if (!ram_we_b && !ram_drive) v = v + 1;
    if (!ram_we_b && !prev_we) v = v + 1;
    if (!ram_oe_b && !prev_oe) v = v + 1;
    if (!ram_we_b && prev_we) begin
      log_addr.push_back(ram_addr); log_wr.push_back(1'b1); log_dat.push_back(ram_dout);
    end
    if (!ram_oe_b && prev_oe) begin
      log_addr.push_back(ram_addr); log_wr.push_back(1'b0); log_dat.push_back(ram_dout);
    end
    viol    <= viol + v;
    prev_we <= ram_we_b;
    prev_oe <= ram_oe_b;
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Expected access list, built from the algorithm definitions.
  logic [ADDR_W-1:0] exp_addr [$];
  logic              exp_wr   [$];
  logic [DATA_W-1:0] exp_dat  [$];

  function automatic logic [15:0] tpat(input int p, input logic [3:0] a);
    case (p)
      0:       return {12'h000, a};
      1:       return a[0] ? 16'hAAAA : 16'h5555;
      2:       return a[0] ? 16'h5555 : 16'hAAAA;
      4:       return 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic add_el(input bit down, input bit two, input bit w0, input int p0,
                        input bit w1, input int p1);
    for (int i = 0; i < N; i++) begin
      logic [3:0] a;
      a = down ? 4'(N - 1 - i) : 4'(i);
      exp_addr.push_back(a); exp_wr.push_back(w0); exp_dat.push_back(tpat(p0, a));
      if (two) begin
        exp_addr.push_back(a); exp_wr.push_back(w1); exp_dat.push_back(tpat(p1, a));
      end
    end
  endtask

  task automatic build_exp(input logic [1:0] m);
    exp_addr.delete(); exp_wr.delete(); exp_dat.delete();
    case (m)
      2'd1: begin
        add_el(0, 0, 1, 1, 0, 0); add_el(0, 0, 0, 1, 0, 0);
        add_el(0, 0, 1, 2, 0, 0); add_el(0, 0, 0, 2, 0, 0);
      end
      2'd2: begin
        add_el(0, 0, 1, 3, 0, 0); add_el(0, 1, 0, 3, 1, 4);
        add_el(1, 1, 0, 4, 1, 3); add_el(1, 0, 0, 3, 0, 0);
      end
      default: begin
        add_el(0, 0, 1, 0, 0, 0); add_el(0, 0, 0, 0, 0, 0); add_el(0, 0, 1, 3, 0, 0);
      end
    endcase
  endtask

  typedef struct {
    logic [1:0]  mode;
    bit          stuck;
    int          inject;
    int          cyc;
    bit          fl;
    logic [3:0]  faddr;
    logic [15:0] fexp;
    logic [15:0] fgot;
    int          nacc;
    int          fin;   // 0: all zero, 1: ~CB, 2: not checked
  } vec_t;

  vec_t vecs [7];

  localparam logic [70:0] RST_VAL = {4'b0000, 2'b11, 1'b0, 4'h0, 16'h0, 4'h0, 16'h0, 16'h0, 8'h00};

  initial begin
    int  cyc, base_log, base_viol, seq_bad, mem_bad, n;
    bit  tmo, found;
    vec_t v;

    vecs[0] = '{2'd3, 1'b0, -1, 192, 1'b0, 4'd0, 16'h0000, 16'h0000, 48, 0};
    vecs[1] = '{2'd0, 1'b0, -1, 192, 1'b0, 4'd0, 16'h0000, 16'h0000, 48, 0};
    vecs[2] = '{2'd1, 1'b0, -1, 256, 1'b0, 4'd0, 16'h0000, 16'h0000, 64, 1};
    vecs[3] = '{2'd2, 1'b0, -1, 384, 1'b0, 4'd0, 16'h0000, 16'h0000, 96, 0};
    vecs[4] = '{2'd2, 1'b1, -1, 139, 1'b1, 4'd9, 16'h0000, 16'h0008, 35, 2};
    vecs[5] = '{2'd1, 1'b1, -1, 231, 1'b1, 4'd9, 16'h5555, 16'h555D, 58, 2};
    vecs[6] = '{2'd0, 1'b1, 50, 192, 1'b0, 4'd0, 16'h0000, 16'h0000, 48, 0};

    r_rst = 1'b1; start = 1'b0; mode = 2'd0; stuck_en = 1'b0;
    repeat (3) @(negedge CLK0_OUT);
    chk("reset_state", {busy, done, pass, fail, ram_we_b, ram_oe_b, ram_drive, ram_addr,
                        ram_dout, fail_addr, fail_exp, fail_got, progress}, RST_VAL);
    r_rst = 1'b0;
    @(negedge CLK0_OUT);

    // Reset in the middle of a March C- run, while a write strobe is low.
    start = 1'b1; mode = 2'd2;
    @(negedge CLK0_OUT);
    start = 1'b0;
    repeat (150) @(negedge CLK0_OUT);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (!ram_we_b) found = 1'b1;
      else @(negedge CLK0_OUT);
    end
    chk("midrun_we_low_seen", found, 1'b1);
    r_rst = 1'b1;
    @(negedge CLK0_OUT);
    chk("midrun_reset_state", {busy, done, pass, fail, ram_we_b, ram_oe_b, ram_drive, ram_addr,
                               ram_dout, fail_addr, fail_exp, fail_got, progress}, RST_VAL);
    r_rst = 1'b0;
    @(negedge CLK0_OUT);
    chk("midrun_stays_idle", {busy, ram_we_b, ram_oe_b}, 3'b011);

    for (int vi = 0; vi < 7; vi++) begin
      v = vecs[vi];
      stuck_en = v.stuck;
      build_exp(v.mode);
      base_log  = log_addr.size();
      base_viol = viol;
      start = 1'b1; mode = v.mode;
      @(negedge CLK0_OUT);
      start = 1'b0;
      chk($sformatf("v%0d_first_cycle", vi),
          {busy, done, pass, fail, fail_addr, fail_exp, fail_got}, {1'b1, 3'b000, 4'h0, 32'h0});
      cyc = 1; tmo = 1'b0;
      forever begin
        if (cyc == v.inject) begin start = 1'b1; mode = 2'd2; end
        else start = 1'b0;
        @(negedge CLK0_OUT);
        if (!busy) break;
        cyc++;
        if (cyc > 3000) begin tmo = 1'b1; break; end
      end
      start = 1'b0;
      chk($sformatf("v%0d_timeout", vi), tmo, 1'b0);
      chk($sformatf("v%0d_busy_cycles", vi), cyc, v.cyc);
      chk($sformatf("v%0d_done_pass_fail", vi), {done, pass, fail}, v.fl ? 3'b001 : 3'b110);
      chk($sformatf("v%0d_progress", vi), progress, v.fl ? 8'h33 : 8'h55);
      if (v.fl) begin
        chk($sformatf("v%0d_fail_addr", vi), fail_addr, v.faddr);
        chk($sformatf("v%0d_fail_exp", vi), fail_exp, v.fexp);
        chk($sformatf("v%0d_fail_got", vi), fail_got, v.fgot);
      end
      repeat (20) @(negedge CLK0_OUT);
      chk($sformatf("v%0d_access_count", vi), log_addr.size() - base_log, v.nacc);
      chk($sformatf("v%0d_held", vi), {busy, done, fail}, v.fl ? 3'b001 : 3'b010);
      n = log_addr.size() - base_log;
      if (n > v.nacc) n = v.nacc;
      seq_bad = 0;
      for (int i = 0; i < n; i++) begin
        if (log_addr[base_log+i] !== exp_addr[i] || log_wr[base_log+i] !== exp_wr[i] ||
            (exp_wr[i] && log_dat[base_log+i] !== exp_dat[i])) seq_bad++;
      end
      chk($sformatf("v%0d_access_sequence", vi), seq_bad, 0);
      chk($sformatf("v%0d_strobe_protocol", vi), viol - base_viol, 0);
      if (v.fin != 2) begin
        mem_bad = 0;
        for (int a = 0; a < N; a++) begin
          if (mem[a] !== ((v.fin == 1) ? tpat(2, 4'(a)) : 16'h0000)) mem_bad++;
        end
        chk($sformatf("v%0d_final_memory", vi), mem_bad, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_march_bist.md
# sram_march_bist

Parametrised external-SRAM built-in self-test engine for the LX9 coprocessor board. It runs a start/done-handshaked test over a configurable address range and data width, with three selectable algorithms: address-pattern, checkerboard and March C-. On the first mismatch it stops and captures the failing address, expected data and read data. It drives the SRAM strobes and address directly; the top level owns the bidirectional data pad.

## Interface
- ADDR_W, 19, SRAM word-address width.
- DATA_W, 32, SRAM data width. Must be a multiple of 16.
- TOP_ADDR, 19'h7FFFF, last address tested. Must be less than 2^ADDR_W.
- CLK0_OUT  in  1  clock. All state changes on its rising edge.
- r_rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle run request. Sampled only in IDLE, DONE or FAIL.
- mode  in  2  algorithm: 0 address, 1 checkerboard, 2 March C-, 3 treated as 0. Latched on start.
- busy  out  1  test in progress.
- done  out  1  run finished without error. Held until the next start.
- pass  out  1  equals done. Cleared when a new run starts.
- fail  out  1  mismatch found. Held until the next start.
- fail_addr  out  ADDR_W  address of the first mismatch.
- fail_exp  out  DATA_W  expected data at that address.
- fail_got  out  DATA_W  data actually read.
- progress  out  8  LED view: ram_addr[ADDR_W-1:ADDR_W-8] while busy, 8'h55 when done, 8'h33 on fail, 8'h00 in IDLE.
- ram_addr  out  ADDR_W  SRAM address.
- ram_dout  out  DATA_W  write data.
- ram_din  in  DATA_W  read data from the pad.
- ram_drive  out  1  pad output enable. Active only during write accesses.
- ram_we_b  out  1  write strobe, active low.
- ram_oe_b  out  1  output enable, active low.

## Operation
- States: IDLE, RUN, DONE, FAIL. RUN iterates over a per-mode list of elements. Each element is one sweep direction plus 1–2 operations per address.
- Mode 0 elements:
  - up w(A)
  - up r(A)
  - up w(0)
- Mode 1 elements:
  - up w(CB)
  - up r(CB)
  - up w(~CB)
  - up r(~CB)
- Mode 2 elements:
  - up w0
  - up r0,w1
  - down r1,w0
  - down r0
- Data patterns:
  - A(addr) = addr[15:0] repeated DATA_W/16 times; address bits above 15 are ignored.
  - CB(addr) = {DATA_W/8{8'h55}} when addr[0]=0, otherwise {DATA_W/8{8'hAA}}.
  - 0 = all zeros; 1 = all ones.
- Sweep ranges: up runs 0..TOP_ADDR; down runs TOP_ADDR..0. An element ends after the access to the final address. There is no wrap.
- In a read-then-write element, each address is read and then written before the address changes.
- State transitions:
  - start in IDLE, DONE or FAIL → RUN. This clears done, pass, fail and fail_* and latches mode.
  - start while busy is ignored.
  - Last element completes → DONE.
  - Any read mismatch → FAIL immediately, with no further accesses.
- FAIL captures fail_addr = ram_addr, fail_exp = the expected pattern and fail_got = the sampled ram_din.
- Reset values, applied in the cycle after r_rst is sampled high, including mid-run:
  - IDLE; ram_we_b=1, ram_oe_b=1, ram_drive=0.
  - ram_addr=0, ram_dout=0.
  - busy, done, pass, fail = 0; fail_* = 0; progress = 0.
  - The current access is abandoned; a WE low pulse ends at that edge.

## Timing
- Every access takes 4 cycles, k0–k3. ram_addr and ram_dout are stable for all four.
  - k0: setup, both strobes high.
  - k1: the relevant strobe is low (ram_we_b for writes, ram_oe_b for reads).
  - k2: both strobes high.
  - k3: advance.
- ram_drive is high in k0–k3 of writes and low in every cycle of a read.
- Read data: ram_din is registered on the edge ending k1 and compared during k2.
  - Mismatch: FAIL is entered on the edge ending k2; busy drops and fail rises that cycle.
  - No mismatch: the next access's k0 follows k3 directly.
- Start latency: start sampled at edge t gives busy=1 and k0 of the first access in cycle t+1.
- Run length in cycles, with N = TOP_ADDR+1:
  - mode 0: 12N
  - mode 1: 16N
  - mode 2: 24N
- Completion: done and pass rise the cycle after the final k3, and busy falls in the same cycle.

## Test plan
- Clean pass (ADDR_W=4, DATA_W=16, TOP_ADDR=15, ideal SRAM model; start with mode 0) → busy for exactly 192 cycles, then done=pass=1, progress=8'h55, all SRAM words 0.
- Checkerboard (mode 1, same parameters) → the model receives 16'h5555 at even and 16'hAAAA at odd addresses; done after 256 cycles; final contents ~CB.
- Stuck bit: model forces bit 3 of address 9 to 1; run mode 2 → fail=1 after the up r0,w1 read at 9, with fail_addr=9, fail_exp=16'h0000, fail_got=16'h0008, progress=8'h33, and no further WE/OE pulses.
- Strobe protocol on every access:
  - exactly one low cycle on ram_we_b or ram_oe_b, never both;
  - ram_drive never high while ram_oe_b is low;
  - in mode 2, the down elements issue addresses 15 down to 0.
- Reset while ram_we_b is low in the middle of mode 2 → the next cycle has all outputs at their reset values. A later start with mode 3 runs mode 0 and passes.
- A start pulse during busy is ignored and the run length is unchanged. A start from FAIL clears fail and fail_* in the cycle busy rises.
